seg7_scan_driver: RTL

- Time-multiplexed scan driver that feeds the 4-digit 7-segment decoder.
- Holds a 16-bit display word and a 4-bit decimal-point mask, and steps through the digits at a programmable refresh rate.
- Presents one digit per slot as a 2-bit digit select, a 4-bit nibble and a dot bit, which drive the decoder's select, binary and dot inputs.
- New values enter through a valid/ready handshake and are applied only at frame boundaries, so the display never shows a mix of old and new digits (no tearing).

---
 rtl/seg7_scan_driver_pkg.sv | 10 +
 rtl/seg7_refresh_prescaler.sv | 31 +++
 rtl/seg7_scan_driver.sv | 92 +++++++++
 3 files changed

// File: rtl/seg7_scan_driver_pkg.sv
// Shared widths and defaults for the 4-digit 7-segment scan driver and its helpers.
package seg7_scan_driver_pkg;

  localparam int unsigned NUM_DIGITS          = 4;
  localparam int unsigned DIGIT_W             = 4;
  localparam int unsigned SEL_W               = 2;
  localparam int unsigned DISP_W              = NUM_DIGITS * DIGIT_W;
  localparam int unsigned REFRESH_DIV_DEFAULT = 100000;

endpackage

// File: rtl/seg7_refresh_prescaler.sv
// Free-running divider producing a one-cycle strobe every REFRESH_DIV clocks (REFRESH_DIV >= 2).
module seg7_refresh_prescaler
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK_OUT
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count;
  logic             at_last;

  assign at_last  = (count == LAST_COUNT);
  assign TICK_OUT = at_last;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (at_last) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit scan driver; new words are staged and swapped in only at frame boundaries.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [DISP_W-1:0]     VALUE_IN,
  input  logic [NUM_DIGITS-1:0] DOT_MASK_IN,
  input  logic                  LOAD_VALID,
  output logic                  LOAD_READY,
  output logic [SEL_W-1:0]      SEG_SELECT,
  output logic [DIGIT_W-1:0]    BIN_OUT,
  output logic                  DOT_OUT,
  output logic                  FRAME_DONE
);

  localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(NUM_DIGITS - 1);

  logic                  tick;
  logic                  boundary;
  logic                  load_accept;
  logic [SEL_W-1:0]      index;
  logic [DISP_W-1:0]     pending_word;
  logic [NUM_DIGITS-1:0] pending_mask;
  logic                  pending_valid;
  logic [DISP_W-1:0]     active_word;
  logic [NUM_DIGITS-1:0] active_mask;
  logic [DIGIT_W-1:0]    cur_nibble;
  logic                  cur_dot;

  seg7_refresh_prescaler #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_prescaler (
    .CLK      (CLK),
    .RESET    (RESET),
    .TICK_OUT (tick)
  );

  assign boundary    = tick && (index == LAST_DIGIT);
  assign LOAD_READY  = ~pending_valid;
  assign load_accept = LOAD_VALID && LOAD_READY;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      index <= '0;
    end else if (tick) begin
      index <= (index == LAST_DIGIT) ? '0 : index + SEL_W'(1);
    end
  end

  // Promotion needs pending_valid and acceptance needs it clear, so a load
  // arriving on a boundary lands in pending and waits for the next frame.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_word  <= '0;
      pending_mask  <= '0;
      pending_valid <= 1'b0;
      active_word   <= '0;
      active_mask   <= '0;
    end else if (boundary && pending_valid) begin
      active_word   <= pending_word;
      active_mask   <= pending_mask;
      pending_valid <= 1'b0;
    end else if (load_accept) begin
      pending_word  <= VALUE_IN;
      pending_mask  <= DOT_MASK_IN;
      pending_valid <= 1'b1;
    end
  end

  always_comb begin
    cur_nibble = active_word[DIGIT_W*index +: DIGIT_W];
    cur_dot    = active_mask[index];
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEG_SELECT <= '0;
      BIN_OUT    <= '0;
      DOT_OUT    <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      SEG_SELECT <= index;
      BIN_OUT    <= cur_nibble;
      DOT_OUT    <= cur_dot;
      FRAME_DONE <= boundary;
    end
  end

endmodule
